rv_div_ctrl: RTL and testbench
==============================

Name: rv_div_ctrl

Overview:
Iterative controller for RV32M DIV/DIVU/REM/REMU. It owns no adder of its own; it time-shares the existing rv_alu through a dedicated operand/control port.
- Per quotient bit: an unsigned compare, then a subtract only when needed.
- Sign fix-up also uses the ALU.
- Sits beside the execute stage. While o_busy is high, the execute-stage ALU input mux selects this block's o_alu_* outputs.

Parameters:
XLEN, 32, operand/result width (only 32 supported)
CNT_W, 5, iteration counter width, $clog2(XLEN)

Ports:
i_clk  input  1  clock; all state updates on rising edge
i_reset_n  input  1  synchronous reset, active-low
i_start  input  1  request; accepted only in IDLE
i_op  input  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
i_src_a  input  32  dividend, sampled on accept
i_src_b  input  32  divisor, sampled on accept
i_kill  input  1  pipeline flush; aborts the operation in flight
o_busy  output  1  high in every state except IDLE
o_valid  output  1  one-cycle pulse; o_result is valid
o_result  output  32  quotient or remainder, registered
o_alu_a  output  32  ALU src_a drive
o_alu_b  output  32  ALU src_b drive
o_alu_ctrl  output  5  ALU control drive
i_alu_result  input  32  combinational ALU result, same cycle

Behaviour:
- Reset (i_reset_n=0 at an edge): state=IDLE, o_busy=0, o_valid=0, o_result=0, counter=0, internal registers=0. Reset overrides start and kill.
- ALU ports when idle: o_alu_a=0, o_alu_b=0, o_alu_ctrl=`ALU_CTRL_ADD.
- Registers: Q (dividend shifting out / quotient shifting in), R (partial remainder), D (divisor), sign flags neg_q and neg_r, 5-bit down-counter.
- Signed flag: signed = !i_op[0].
- Accept (IDLE and i_start): latch operands and op.
  - neg_q = signed & (a[31]^b[31]) & (b!=0).
  - neg_r = signed & a[31].
- Special cases on accept skip all work states and go directly to DONE:
  - b==0: quotient=0xFFFFFFFF, remainder=a.
  - signed, a==0x80000000 and b==0xFFFFFFFF: quotient=0x80000000, remainder=0.
- States and transitions (each work state lasts exactly one cycle):
  - IDLE: on accept -> NEG_A if signed&a[31], else NEG_B if signed&b[31], else CMP.
  - NEG_A: ALU SUB with a=0, b=Q; Q<=result. Next -> NEG_B if signed&D[31], else CMP.
  - NEG_B: ALU SUB with a=0, b=D; D<=result. Next -> CMP.
  - CMP:
    - Rs = {R[30:0], Q[31]}. ALU `ALU_CMP_NLTU with a=Rs, b=D.
    - ge = R[31] | i_alu_result[0]. R[31] covers the 33-bit case.
    - R<=Rs; Q<={Q[30:0], ge}.
    - Next -> SUB if ge; else if counter==0 -> FIX/DONE; else counter--, CMP.
  - SUB: ALU SUB with a=R, b=D; R<=result. Next -> CMP with counter--, or FIX/DONE when counter==0.
  - FIX: op REM/REMU: result=R; op DIV/DIVU: result=Q. If the relevant flag (neg_r for REM, neg_q for DIV) is set, ALU SUB with a=0, b=result. Entered only when negation is needed. Next -> DONE.
  - DONE: o_valid=1 for exactly this cycle; o_result loaded on the DONE entry edge. Next -> IDLE. A new i_start is accepted in the IDLE cycle that follows, not in DONE.
- Latency: the o_valid cycle comes (number of work states + 1) cycles after the accept cycle.
  - Work states = NEG_A + NEG_B + 32 CMP + popcount(unsigned quotient) SUB + FIX.
  - Range: 1 (special case) to 67.
- o_result holds its value until the next DONE entry or reset.
- i_kill: in any non-IDLE state, next state=IDLE, no o_valid, o_result unchanged. Kill in IDLE is ignored. Kill together with i_start in IDLE: request is not accepted.
- i_start while busy: ignored; no queueing.
- ALU arithmetic is modulo 2^32. Quotient and remainder bits beyond 32 are discarded.

Decomposition:
- Shared package rv_div_pkg:
  - state enum div_state_t {IDLE, NEG_A, NEG_B, CMP, SUB, FIX, DONE}
  - op localparams DIV_OP_DIV/DIVU/REM/REMU
  - special-case constants DIV_BY_ZERO_Q = 32'hFFFFFFFF, DIV_OVF_Q = 32'h80000000
- ALU control codes come from rv_defines.vh (`ALU_CTRL_SUB, `ALU_CMP_NLTU, `ALU_CTRL_ADD).
- No sub-module; the FSM and the datapath registers form a single module. The bench instantiates rv_alu and connects it to the o_alu_* / i_alu_result ports.

Test Plan:
- DIVU a=100, b=7 -> o_result=14; 35 work states, so o_valid 36 cycles after accept; o_busy high throughout.
- REM a=0xFFFFFFF9 (-7), b=2 -> o_result=0xFFFFFFFF (-1). DIV same operands -> 0xFFFFFFFD (-3); path passes NEG_A and FIX.
- DIV a=5, b=0 -> o_result=0xFFFFFFFF with o_valid the cycle after accept. REMU a=5, b=0 -> 5.
- DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000 in 1 cycle. REM same operands -> 0.
- DIVU a=0xFFFFFFFF, b=1 -> 0xFFFFFFFF, 64 work states (maximum unsigned latency). Assert i_kill at cycle 10 of a repeat -> IDLE next cycle, no o_valid, o_result still 0xFFFFFFFF.
- Reset mid-operation (cycle 20 of DIVU 1000/3) -> next cycle o_busy=0, o_result=0. Then DIVU 1000/3 -> 333, and REMU 1000/3 -> 1.

Source files
------------

// File: rtl/rv_div_pkg.sv
// Shared types and constants for the iterative RV32M divide controller.
package rv_div_pkg;

    // One state per ALU-sharing step; every work state lasts exactly one cycle.
    typedef enum logic [2:0] {
        IDLE,
        NEG_A,
        NEG_B,
        CMP,
        SUB,
        FIX,
        DONE
    } div_state_t;

    // funct3[1:0] encodings of the four M-extension divide operations.
    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    // Architected results for divide-by-zero and signed overflow.
    localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] DIV_OVF_Q     = 32'h8000_0000;

    // DIV and REM are signed; the unsigned variants have funct3[0] set.
    function automatic logic is_signed_op(input logic [1:0] op);
        return ~op[0];
    endfunction

    // REM and REMU return the remainder rather than the quotient.
    function automatic logic is_rem_op(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/rv_alu.sv
// Execute-stage ALU (the subset of operations the divider time-shares).
`ifndef RV_DEFINES_VH
`define RV_DEFINES_VH
`define ALU_CTRL_ADD  5'd0
`define ALU_CTRL_SUB  5'd1
`define ALU_CTRL_AND  5'd2
`define ALU_CTRL_OR   5'd3
`define ALU_CTRL_XOR  5'd4
`define ALU_CMP_LTU   5'd5
`define ALU_CMP_NLTU  5'd6
`endif

module rv_alu (
    input  logic [31:0] i_src_a,
    input  logic [31:0] i_src_b,
    input  logic [4:0]  i_alu_ctrl,
    output logic [31:0] o_result
);

    // Purely combinational result; the divider consumes it in the same cycle.
    always_comb begin
        o_result = '0;
        case (i_alu_ctrl)
            `ALU_CTRL_ADD: o_result = i_src_a + i_src_b;
            `ALU_CTRL_SUB: o_result = i_src_a - i_src_b;
            `ALU_CTRL_AND: o_result = i_src_a & i_src_b;
            `ALU_CTRL_OR:  o_result = i_src_a | i_src_b;
            `ALU_CTRL_XOR: o_result = i_src_a ^ i_src_b;
            `ALU_CMP_LTU:  o_result = {31'd0, (i_src_a <  i_src_b)};
            `ALU_CMP_NLTU: o_result = {31'd0, (i_src_a >= i_src_b)};
            default:       o_result = '0;
        endcase
    end

endmodule

// File: rtl/rv_div_ctrl.sv
// Iterative restoring divider controller for DIV/DIVU/REM/REMU that borrows
// the execute-stage ALU for every compare, subtract and sign negation.
`ifndef RV_DEFINES_VH
`define RV_DEFINES_VH
`define ALU_CTRL_ADD  5'd0
`define ALU_CTRL_SUB  5'd1
`define ALU_CTRL_AND  5'd2
`define ALU_CTRL_OR   5'd3
`define ALU_CTRL_XOR  5'd4
`define ALU_CMP_LTU   5'd5
`define ALU_CMP_NLTU  5'd6
`endif

module rv_div_ctrl
    import rv_div_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic            i_start,
    input  logic [1:0]      i_op,
    input  logic [XLEN-1:0] i_src_a,
    input  logic [XLEN-1:0] i_src_b,
    input  logic            i_kill,
    output logic            o_busy,
    output logic            o_valid,
    output logic [XLEN-1:0] o_result,
    output logic [XLEN-1:0] o_alu_a,
    output logic [XLEN-1:0] o_alu_b,
    output logic [4:0]      o_alu_ctrl,
    input  logic [XLEN-1:0] i_alu_result
);

    div_state_t       state_q, state_d;
    logic [XLEN-1:0]  q_q, q_d;           // dividend shifting out, quotient shifting in
    logic [XLEN-1:0]  r_q, r_d;           // partial remainder
    logic [XLEN-1:0]  d_q, d_d;           // divisor (magnitude after NEG_B)
    logic [XLEN-1:0]  result_q, result_d;
    logic [1:0]       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             neg_q_q, neg_q_d;
    logic             neg_r_q, neg_r_d;

    logic [XLEN-1:0]  rs;
    logic             ge;
    logic             fix_needed;
    logic             start_signed;

    assign rs           = {r_q[XLEN-2:0], q_q[XLEN-1]};
    // A set R[31] means the shifted remainder is a 33-bit value, always >= D.
    assign ge           = r_q[XLEN-1] | i_alu_result[0];
    assign fix_needed   = is_rem_op(op_q) ? neg_r_q : neg_q_q;
    assign start_signed = is_signed_op(i_op);

    assign o_busy   = (state_q != IDLE);
    assign o_valid  = (state_q == DONE);
    assign o_result = result_q;

    // Next-state, datapath updates and ALU drive for the current step.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        state_d    = state_q;
        q_d        = q_q;
        r_d        = r_q;
        d_d        = d_q;
        result_d   = result_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        neg_q_d    = neg_q_q;
        neg_r_d    = neg_r_q;
        o_alu_a    = '0;
        o_alu_b    = '0;
        o_alu_ctrl = `ALU_CTRL_ADD;

        case (state_q)
            IDLE: begin
                if (i_start && !i_kill) begin
                    q_d     = i_src_a;
                    d_d     = i_src_b;
                    r_d     = '0;
                    op_d    = i_op;
                    cnt_d   = {CNT_W{1'b1}};
                    neg_q_d = start_signed & (i_src_a[XLEN-1] ^ i_src_b[XLEN-1]) & (i_src_b != '0);
                    neg_r_d = start_signed & i_src_a[XLEN-1];
                    if (i_src_b == '0) begin
                        state_d  = DONE;
                        result_d = is_rem_op(i_op) ? i_src_a : DIV_BY_ZERO_Q;
                    end else if (start_signed && i_src_a == DIV_OVF_Q && i_src_b == '1) begin
                        state_d  = DONE;
                        result_d = is_rem_op(i_op) ? '0 : DIV_OVF_Q;
                    end else if (start_signed && i_src_a[XLEN-1]) begin
                        state_d = NEG_A;
                    end else if (start_signed && i_src_b[XLEN-1]) begin
                        state_d = NEG_B;
                    end else begin
                        state_d = CMP;
                    end
                end
            end
            NEG_A: begin
                o_alu_ctrl = `ALU_CTRL_SUB;
                o_alu_b    = q_q;
                q_d        = i_alu_result;
                state_d    = (is_signed_op(op_q) && d_q[XLEN-1]) ? NEG_B : CMP;
            end
            NEG_B: begin
                o_alu_ctrl = `ALU_CTRL_SUB;
                o_alu_b    = d_q;
                d_d        = i_alu_result;
                state_d    = CMP;
            end
            CMP: begin
                o_alu_ctrl = `ALU_CMP_NLTU;
                o_alu_a    = rs;
                o_alu_b    = d_q;
                r_d        = rs;
                q_d        = {q_q[XLEN-2:0], ge};
                if (ge) begin
                    state_d = SUB;
                end else if (cnt_q == '0) begin
                    state_d  = fix_needed ? FIX : DONE;
                    result_d = is_rem_op(op_q) ? r_d : q_d;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                    state_d = CMP;
                end
            end
            SUB: begin
                o_alu_ctrl = `ALU_CTRL_SUB;
                o_alu_a    = r_q;
                o_alu_b    = d_q;
                r_d        = i_alu_result;
                if (cnt_q == '0) begin
                    state_d  = fix_needed ? FIX : DONE;
                    result_d = is_rem_op(op_q) ? r_d : q_d;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                    state_d = CMP;
                end
            end
            FIX: begin
                o_alu_ctrl = `ALU_CTRL_SUB;
                o_alu_b    = is_rem_op(op_q) ? r_q : q_q;
                result_d   = i_alu_result;
                state_d    = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A flush abandons the operation and leaves the last result visible.
        if (i_kill && state_q != IDLE) begin
            state_d  = IDLE;
            result_d = result_q;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (!i_reset_n) begin
            state_q  <= IDLE;
            q_q      <= '0;
            r_q      <= '0;
            d_q      <= '0;
            result_q <= '0;
            op_q     <= DIV_OP_DIV;
            cnt_q    <= '0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            q_q      <= q_d;
            r_q      <= r_d;
            d_q      <= d_d;
            result_q <= result_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
        end
    end

endmodule

// File: tb/tb_rv_div_ctrl.sv
// Directed self-checking bench for rv_div_ctrl paired with rv_alu.
`ifndef RV_DEFINES_VH
`define RV_DEFINES_VH
`define ALU_CTRL_ADD  5'd0
`define ALU_CTRL_SUB  5'd1
`define ALU_CTRL_AND  5'd2
`define ALU_CTRL_OR   5'd3
`define ALU_CTRL_XOR  5'd4
`define ALU_CMP_LTU   5'd5
`define ALU_CMP_NLTU  5'd6
`endif

module tb_rv_div_ctrl;
    import rv_div_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        kill;
    logic        busy;
    logic        valid;
    logic [31:0] result;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  alu_ctrl;
    logic [31:0] alu_res;

    int checks = 0;
    int errors = 0;

    rv_div_ctrl #(.XLEN(32), .CNT_W(5)) dut (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_start      (start),
        .i_op         (op),
        .i_src_a      (src_a),
        .i_src_b      (src_b),
        .i_kill       (kill),
        .o_busy       (busy),
        .o_valid      (valid),
        .o_result     (result),
        .o_alu_a      (alu_a),
        .o_alu_b      (alu_b),
        .o_alu_ctrl   (alu_ctrl),
        .i_alu_result (alu_res)
    );

    rv_alu u_alu (
        .i_src_a    (alu_a),
        .i_src_b    (alu_b),
        .i_alu_ctrl (alu_ctrl),
        .o_result   (alu_res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic accept(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at cycle n0 after accept; returns the cycle o_valid was seen.
    task automatic wait_done(input int n0, output int n, output bit seen, output bit busy_ok);
        n       = n0;
        seen    = 1'b0;
        busy_ok = 1'b1;
        while (n <= 120) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int n;
        bit seen;
        bit busy_ok;
        accept(o, a, b);
        wait_done(1, n, seen, busy_ok);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s timeout: no o_valid within 120 cycles", name);
        end else begin
            checks++;
            if (n != exp_lat) begin
                errors++;
                $display("FAIL %s latency: got %0d expected %0d", name, n, exp_lat);
            end
            checks++;
            if (result !== exp_res) begin
                errors++;
                $display("FAIL %s result: got %h expected %h", name, result, exp_res);
            end
            checks++;
            if (!busy_ok) begin
                errors++;
                $display("FAIL %s busy: o_busy dropped before o_valid", name);
            end
            @(negedge clk);
            checks++;
            if (valid !== 1'b0 || busy !== 1'b0 || result !== exp_res) begin
                errors++;
                $display("FAIL %s after_done: valid=%b busy=%b result=%h expected 0 0 %h",
                         name, valid, busy, result, exp_res);
            end
        end
    endtask

    task automatic check_idle(input string name, input logic [31:0] exp_res);
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0 || result !== exp_res ||
            alu_a !== 32'd0 || alu_b !== 32'd0 || alu_ctrl !== `ALU_CTRL_ADD) begin
            errors++;
            $display("FAIL %s idle: busy=%b valid=%b result=%h alu=%h/%h/%h expected 0 0 %h 0/0/%h",
                     name, busy, valid, result, alu_a, alu_b, alu_ctrl, exp_res, `ALU_CTRL_ADD);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        kill  = 1'b1;
        op    = DIV_OP_DIVU;
        src_a = 32'd100;
        src_b = 32'd7;
        repeat (2) @(negedge clk);
        check_idle("reset_held", 32'd0);
        start = 1'b0;
        kill  = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("reset_released", 32'd0);
    endtask

    task automatic test_unsigned();
        run_op("divu_100_7", DIV_OP_DIVU, 32'd100, 32'd7, 32'd14, 36);
        run_op("remu_100_7", DIV_OP_REMU, 32'd100, 32'd7, 32'd2, 36);
    endtask

    task automatic test_signed();
        run_op("rem_m7_2",    DIV_OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 37);
        run_op("div_m7_2",    DIV_OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 37);
        run_op("div_100_m7",  DIV_OP_DIV, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 38);
        run_op("rem_100_m7",  DIV_OP_REM, 32'd100, 32'hFFFF_FFF9, 32'd2, 37);
        run_op("div_m100_m7", DIV_OP_DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 38);
        run_op("rem_m100_m7", DIV_OP_REM, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 39);
    endtask

    task automatic test_special();
        run_op("div_by_zero",  DIV_OP_DIV,  32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("remu_by_zero", DIV_OP_REMU, 32'd5, 32'd0, 32'd5, 1);
        run_op("div_overflow", DIV_OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_overflow", DIV_OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    endtask

    task automatic test_kill();
        run_op("divu_max", DIV_OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 65);
        accept(DIV_OP_DIVU, 32'hFFFF_FFFF, 32'd1);
        repeat (9) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0 || result !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL kill_mid: busy=%b valid=%b result=%h expected 0 0 ffffffff", busy, valid, result);
        end
        // Kill together with start in IDLE must not accept the request.
        start = 1'b1;
        kill  = 1'b1;
        op    = DIV_OP_DIVU;
        src_a = 32'd50;
        src_b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        kill  = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("kill_with_start", 32'hFFFF_FFFF);
    endtask

    task automatic test_back_to_back();
        int n;
        bit seen;
        bit busy_ok;
        accept(DIV_OP_DIVU, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        // Cycle 5: a start while busy is dropped.
        start = 1'b1;
        src_a = 32'd200;
        src_b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        wait_done(6, n, seen, busy_ok);
        checks++;
        if (!seen || n != 36 || result !== 32'd14 || !busy_ok) begin
            errors++;
            $display("FAIL busy_start: seen=%b cycle=%0d result=%h busy_ok=%b expected 1 36 0000000e 1",
                     seen, n, result, busy_ok);
        end
        // Start raised in the DONE cycle is only taken in the following IDLE cycle.
        start = 1'b1;
        op    = DIV_OP_DIVU;
        src_a = 32'd9;
        src_b = 32'd3;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL done_start: busy=%b expected 0 in cycle after DONE", busy);
        end
        @(negedge clk);
        start = 1'b0;
        wait_done(1, n, seen, busy_ok);
        checks++;
        if (!seen || n != 35 || result !== 32'd3 || !busy_ok) begin
            errors++;
            $display("FAIL idle_start: seen=%b cycle=%0d result=%h busy_ok=%b expected 1 35 00000003 1",
                     seen, n, result, busy_ok);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        accept(DIV_OP_DIVU, 32'd1000, 32'd3);
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_idle("reset_mid", 32'd0);
        run_op("divu_1000_3", DIV_OP_DIVU, 32'd1000, 32'd3, 32'd333, 38);
        run_op("remu_1000_3", DIV_OP_REMU, 32'd1000, 32'd3, 32'd1, 38);
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_special();
        test_kill();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
